plot_arbiter: RTL and testbench
===============================

# plot_arbiter

Four-player pixel-plot arbiter and screen-clear sequencer for the DE2Tron display path. It sits between the per-player position sources and the 160x120 `vga_adapter`, which can take one pixel per clock. Each cycle it picks at most one pixel source: a player, by round-robin, or the full-screen clear sweep. It drives `x`/`y`/`colour`/`plot` as registered outputs.

## Interface
No parameters. Screen size is fixed at 160x120. Player colours are fixed:
- p1 = 3'b001
- p2 = 3'b010
- p3 = 3'b100
- p4 = 3'b110

Ports:
- `CLOCK_50`  in  1  — single clock for the block; all logic is on its rising edge.
- `resetn`  in  1  — synchronous, active-low reset.
- `req`  in  4  — per-player plot request, level-sensitive. `req[0]` is p1. The requester holds it until it sees its `gnt` bit.
- `p1`, `p2`, `p3`, `p4`  in  15 each  — player position, `{x[7:0], y[6:0]}`. Sampled in the arbitration cycle.
- `clear_req`  in  1  — start a full-screen clear; a single-cycle pulse is enough.
- `clear_colour`  in  3  — fill colour, latched when the clear starts.
- `gnt`  out  4  — one-hot, one cycle long. Marks the pixel issued on this cycle's outputs.
- `busy_clear`  out  1  — high while the clear sweep is running.
- `x`  out  8  — pixel x to the VGA adapter.
- `y`  out  7  — pixel y to the VGA adapter.
- `colour`  out  3  — pixel colour to the VGA adapter.
- `plot`  out  1  — write enable to the VGA adapter.

## Operation
- **Reset values.** `x=0`, `y=0`, `colour=0`, `plot=0`, `gnt=0`, `busy_clear=0`. The FSM is in IDLE and the round-robin pointer gives p1 highest priority. Reset mid-clear aborts the sweep; it does not resume.
- **FSM states.** IDLE and CLEAR.
  - IDLE → CLEAR when `clear_req=1` (requires the macro). Clear takes priority over any `req`.
  - CLEAR → IDLE after the pixel (159,119) is issued.
  - `clear_req` while in CLEAR is ignored.
- **Arbitration in IDLE.**
  - Eligible requesters are those with `req` high, minus the requester granted in the previous cycle. That requester is masked for exactly one cycle, so a requester that drops `req` on seeing `gnt` gets exactly one pixel.
  - Among eligible requesters, priority is round-robin starting at the player after the last grant, wrapping p4 → p1.
  - The pointer advances only on a grant. Clear sweeps do not change it.
- **Grant.** At the edge:
  - `gnt[k]` is set to 1.
  - `x` and `y` are loaded from `pk`; `colour` is set to the player's fixed colour.
  - `plot` is set to 1, unless the position is off-screen (`x>159` or `y>119`). In that case `plot=0` and the pixel is dropped, but `gnt[k]` still pulses so the request is consumed.
- **No eligible requester.** `plot=0` and `gnt=0`. `x`, `y` and `colour` hold their last values.
- **Clear sweep.**
  - Coordinate order is x from 0 to 159 (inner loop), then y from 0 to 119 (outer loop): 19200 pixels, one per cycle.
  - `plot=1` on every sweep pixel; `colour` is the latched `clear_colour`.
  - `gnt=0` throughout the sweep; `req` lines are ignored.
- **Counters.** x counter is 8 bits and wraps 159 → 0 with y incrementing. y counter is 7 bits.

## Timing
- **Grant latency.** If `req[k]` is eligible and selected in cycle N, then `gnt[k]`, `plot` and the coordinates are valid in cycle N+1.
- **Throughput.** One pixel per cycle. With all four `req` held, each player gets 1 pixel in 4 cycles. With only one `req` held, that player gets 1 pixel in 2 cycles.
- **Clear timing.** `clear_req` sampled at edge N gives:
  - `busy_clear=1` and pixel (0,0) in cycle N+1;
  - the last pixel, (159,119), in cycle N+19200;
  - `busy_clear=0` and `plot=0` in cycle N+19201;
  - the earliest player pixel in cycle N+19202.
- **Simultaneous `clear_req` and `req` in IDLE.** Clear wins. Pending requests wait, holding their `req`.

## Configuration
- **`PLOT_CLEAR_EN`**
  - Defined: the CLEAR state, the sweep counters and the `clear_colour` latch are compiled in, as described above.
  - Undefined: `clear_req` and `clear_colour` are ignored, `busy_clear` is tied to 0, and the block is a pure four-way round-robin plot arbiter.

## Test plan
- **Reset.** Assert `resetn=0` with `req=4'b1111`. Required: all outputs 0. After release, the first grant goes to p1.
- **Single request.** Apply `req=4'b0001` with `p1={8'd10,7'd20}`, and drop `req` on `gnt`. Required, next cycle: `gnt=0001`, `plot=1`, `x=10`, `y=20`, `colour=001`. The cycle after: `plot=0`, `gnt=0`.
- **Round robin.** Hold `req=4'b1111`. Required, on consecutive cycles: `gnt` = 0001, 0010, 0100, 1000, 0001; colours 001, 010, 100, 110, 001; `plot=1` every cycle.
- **Mask and off-screen.**
  - Hold only `req[1]`. Required: `gnt` alternates 0010, 0000.
  - Apply `req=4'b0100` with `p3={8'd160,7'd5}`. Required: `gnt=0100`, `plot=0`.
- **Clear (macro defined).** Pulse `clear_req` with `clear_colour=3'b111` and `req=4'b1111`. Required:
  - `busy_clear` high for exactly 19200 cycles, with no grants during that time;
  - pixel (159,0) is followed by (0,1);
  - the last pixel is (159,119);
  - after the sweep, arbitration resumes from the pointer that was held before the clear.
- **Reset mid-clear.** Assert `resetn=0` at pixel 100 of a sweep. Required: all outputs 0 on the next cycle and IDLE after release. A build without `PLOT_CLEAR_EN` must show `busy_clear` constantly 0 when `clear_req` is pulsed.

Source files
------------

// File: rtl/plot_arbiter.sv
// plot_arbiter: four-player round-robin pixel arbiter and 160x120 clear sweeper feeding vga_adapter.
// The clear sweep is compiled in only when PLOT_CLEAR_EN is defined.
module plot_arbiter (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [14:0] p1,
    input  logic [14:0] p2,
    input  logic [14:0] p3,
    input  logic [14:0] p4,
    input  logic        clear_req,
    input  logic [2:0]  clear_colour,
    output logic [3:0]  gnt,
    output logic        busy_clear,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);
    logic [1:0]  ptr, pick;
    logic [3:0]  elig, gnt_d;
    logic        found, grant, in_clear, clear_go, last_px, plot_d;
    logic [14:0] pos;
    logic [7:0]  x_d;
    logic [6:0]  y_d;
    logic [2:0]  colour_d, pcol;

    assign last_px = x == 8'd159 && y == 7'd119;

`ifdef PLOT_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, next_state;

    always_ff @(posedge CLOCK_50)
        state <= !resetn ? IDLE : next_state;

    always_comb
        next_state = state == IDLE ? (clear_req ? CLEAR : IDLE) : (last_px ? IDLE : CLEAR);

    assign in_clear = state == CLEAR;
    assign clear_go = state == IDLE && clear_req;
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req;
    assign in_clear = 1'b0;
    assign clear_go = 1'b0;
`endif

    assign busy_clear = in_clear;

    // Last cycle's grantee is masked so a requester dropping req on gnt gets one pixel.
    assign elig = req & ~gnt;

    // Scan offsets downward so the player nearest after ptr wins.
    always_comb begin
        pick = ptr;
        found = 1'b0;
        for (int i = 4; i >= 1; i--)
            if (elig[ptr + 2'(i)]) begin
                pick = ptr + 2'(i);
                found = 1'b1;
            end
    end

    assign grant = found && !in_clear && !clear_go;
    assign pos = pick == 2'd0 ? p1 : pick == 2'd1 ? p2 : pick == 2'd2 ? p3 : p4;
    assign pcol = pick == 2'd0 ? 3'b001 : pick == 2'd1 ? 3'b010 : pick == 2'd2 ? 3'b100 : 3'b110;

    // The output x/y registers double as the sweep counters.
    always_comb begin
        x_d = x;
        y_d = y;
        colour_d = colour;
        plot_d = 1'b0;
        gnt_d = 4'b0000;
        if (clear_go) begin
            x_d = 8'd0;
            y_d = 7'd0;
            colour_d = clear_colour;
            plot_d = 1'b1;
        end else if (in_clear) begin
            if (!last_px) begin
                x_d = x == 8'd159 ? 8'd0 : x + 8'd1;
                y_d = x == 8'd159 ? y + 7'd1 : y;
                plot_d = 1'b1;
            end
        end else if (grant) begin
            x_d = pos[14:7];
            y_d = pos[6:0];
            colour_d = pcol;
            plot_d = pos[14:7] <= 8'd159 && pos[6:0] <= 7'd119;
            gnt_d = 4'b0001 << pick;
        end
    end

    always_ff @(posedge CLOCK_50)
        if (!resetn) begin
            x <= 8'd0;
            y <= 7'd0;
            colour <= 3'd0;
            plot <= 1'b0;
            gnt <= 4'b0000;
            ptr <= 2'd3;
        end else begin
            x <= x_d;
            y <= y_d;
            colour <= colour_d;
            plot <= plot_d;
            gnt <= gnt_d;
            if (grant)
                ptr <= pick;
        end
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed vectors for plot_arbiter with a behavioural reference model checked every cycle.
// Covers the clear sweep when PLOT_CLEAR_EN is defined, and its absence otherwise.
module tb_plot_arbiter;
    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b0;
    logic        clear_req = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [2:0]  clear_colour = 3'b000;
    logic [14:0] pp [4];
    logic [3:0]  gnt;
    logic        busy_clear;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    int passed = 0, total = 0;

`ifdef PLOT_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    plot_arbiter dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req),
        .p1(pp[0]), .p2(pp[1]), .p3(pp[2]), .p4(pp[3]),
        .clear_req(clear_req), .clear_colour(clear_colour),
        .gnt(gnt), .busy_clear(busy_clear), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLOCK_50);
            #3;
        end
    endtask

    function automatic int pcolour(input int j);
        return j == 0 ? 1 : j == 1 ? 2 : j == 2 ? 4 : 6;
    endfunction

    // Reference model: last grantee index, last-cycle grantee, sweep pixel index.
    int m_last = 3, m_prev = -1, m_k = 0, sel;
    bit m_clear = 1'b0;
    int e_x = 0, e_y = 0, e_col = 0, e_plot = 0, e_gnt = 0, e_busy = 0;

    always @(posedge CLOCK_50) begin
        if (!resetn) begin
            m_last = 3; m_prev = -1; m_clear = 1'b0;
            e_x = 0; e_y = 0; e_col = 0; e_plot = 0; e_gnt = 0; e_busy = 0;
        end else if (m_clear) begin
            e_gnt = 0;
            m_prev = -1;
            if (m_k == 160 * 120 - 1) begin
                m_clear = 1'b0; e_busy = 0; e_plot = 0;
            end else begin
                m_k++;
                e_x = m_k % 160; e_y = m_k / 160; e_plot = 1;
            end
        end else if (CLEAR_EN && clear_req) begin
            m_clear = 1'b1; m_k = 0; m_prev = -1;
            e_x = 0; e_y = 0; e_col = int'(clear_colour); e_plot = 1; e_busy = 1; e_gnt = 0;
        end else begin
            sel = -1;
            for (int off = 4; off >= 1; off--)
                if (req[(m_last + off) % 4] && (m_last + off) % 4 != m_prev)
                    sel = (m_last + off) % 4;
            e_gnt = 0; e_plot = 0; m_prev = sel;
            if (sel >= 0) begin
                e_gnt = 1 << sel;
                e_x = int'(pp[sel][14:7]);
                e_y = int'(pp[sel][6:0]);
                e_col = pcolour(sel);
                e_plot = (e_x < 160 && e_y < 120) ? 1 : 0;
                m_last = sel;
            end
        end
        #2;
        chk("m_gnt", gnt, e_gnt);
        chk("m_busy", busy_clear, e_busy);
        chk("m_x", x, e_x);
        chk("m_y", y, e_y);
        chk("m_colour", colour, e_col);
        chk("m_plot", plot, e_plot);
    end

    int rr_g [5] = '{1, 2, 4, 8, 1};
    int rr_c [5] = '{1, 2, 4, 6, 1};
    int n, ngnt, last_x, last_y, prev_x, prev_y;
    bit wrap_ok;

    initial begin
        pp[0] = {8'd30, 7'd40};
        pp[1] = {8'd50, 7'd60};
        pp[2] = {8'd100, 7'd100};
        pp[3] = {8'd159, 7'd119};
        req = 4'b1111;
        tick(3);
        chk("rst_gnt", gnt, 0);
        chk("rst_plot", plot, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_busy", busy_clear, 0);
        resetn = 1'b1;
        tick();
        chk("first_gnt", gnt, 1);
        req = 4'b0000;
        tick();
        pp[0] = {8'd10, 7'd20};
        req = 4'b0001;
        tick();
        chk("single_gnt", gnt, 1);
        chk("single_plot", plot, 1);
        chk("single_x", x, 10);
        chk("single_y", y, 20);
        chk("single_colour", colour, 1);
        req = 4'b0000;
        tick();
        chk("single_after_plot", plot, 0);
        chk("single_after_gnt", gnt, 0);
        chk("single_hold_x", x, 10);
        req = 4'b1000;
        tick();
        chk("p4_gnt", gnt, 8);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_gnt", gnt, rr_g[i]);
            chk("rr_colour", colour, rr_c[i]);
            chk("rr_plot", plot, 1);
        end
        req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mask_gnt", gnt, (i % 2 == 0) ? 2 : 0);
        end
        pp[2] = {8'd160, 7'd5};
        req = 4'b0100;
        tick();
        chk("offx_gnt", gnt, 4);
        chk("offx_plot", plot, 0);
        req = 4'b0000;
        tick();
        pp[2] = {8'd10, 7'd120};
        req = 4'b0100;
        tick();
        chk("offy_gnt", gnt, 4);
        chk("offy_plot", plot, 0);
        req = 4'b0000;
        pp[2] = {8'd100, 7'd100};
        tick();
`ifdef PLOT_CLEAR_EN
        req = 4'b1111;
        clear_req = 1'b1;
        clear_colour = 3'b111;
        tick();
        clear_req = 1'b0;
        chk("clr_busy", busy_clear, 1);
        chk("clr_x0", x, 0);
        chk("clr_y0", y, 0);
        chk("clr_plot", plot, 1);
        chk("clr_colour", colour, 7);
        chk("clr_gnt", gnt, 0);
        n = 1; ngnt = 0; wrap_ok = 1'b0; last_x = 0; last_y = 0;
        while (busy_clear && n < 20000) begin
            prev_x = int'(x);
            prev_y = int'(y);
            clear_req = (n == 50);
            tick();
            if (busy_clear) begin
                n++;
                if (gnt != 4'b0000) ngnt++;
                if (prev_x == 159 && prev_y == 0 && x == 8'd0 && y == 7'd1) wrap_ok = 1'b1;
                last_x = int'(x);
                last_y = int'(y);
            end
        end
        clear_req = 1'b0;
        chk("clr_cycles", n, 19200);
        chk("clr_no_gnt", ngnt, 0);
        chk("clr_wrap", wrap_ok, 1);
        chk("clr_last_x", last_x, 159);
        chk("clr_last_y", last_y, 119);
        chk("clr_end_plot", plot, 0);
        tick();
        chk("clr_resume_gnt", gnt, 8);
        chk("clr_resume_plot", plot, 1);
        req = 4'b0000;
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick(100);
        chk("mid_x", x, 100);
        chk("mid_busy", busy_clear, 1);
        resetn = 1'b0;
        tick();
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_busy", busy_clear, 0);
        chk("mid_rst_x", x, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_colour", colour, 0);
        chk("mid_rst_plot", plot, 0);
        resetn = 1'b1;
        req = 4'b0001;
        tick();
        chk("mid_idle_gnt", gnt, 1);
        chk("mid_idle_busy", busy_clear, 0);
        req = 4'b0000;
        tick();
`else
        clear_req = 1'b1;
        clear_colour = 3'b111;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("noclr_busy", busy_clear, 0);
            chk("noclr_plot", plot, 0);
            tick();
        end
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
